// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions for the memory stage.
// Contents: instruction codes, status codes, register IDs, the stage state
// enum and a decoder that tells which memory access an instruction makes.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam logic [3:0] RSP   = 4'd4;
    localparam logic [3:0] RNONE = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_HOLD   = 2'd2,
        ST_HALTED = 2'd3
    } stage_state_t;

    // What the memory stage has to do for one instruction.
    typedef struct packed {
        logic is_access;       // instruction touches data memory
        logic is_write;        // 1 = store, 0 = load
        logic use_val_a_addr;  // ret/popq address from val_a instead of val_e
        logic use_val_p_data;  // call stores the return address (val_p)
    } mem_op_t;

    function automatic mem_op_t decode_mem_op(input logic [3:0] icode);
        mem_op_t op;
        op = '0;
        case (icode)
            I_RMMOVQ, I_PUSHQ: begin
                op.is_access = 1'b1;
                op.is_write  = 1'b1;
            end
            I_MRMOVQ: begin
                op.is_access = 1'b1;
            end
            I_CALL: begin
                op.is_access      = 1'b1;
                op.is_write       = 1'b1;
                op.use_val_p_data = 1'b1;
            end
            I_RET, I_POPQ: begin
                op.is_access      = 1'b1;
                op.use_val_a_addr = 1'b1;
            end
            default: begin
                op = '0;
            end
        endcase
        return op;
    endfunction

endpackage

// File: rtl/mem_access_ctrl.sv
// Memory request engine for the memory stage.
// Holds the request registers (req/we/addr/wdata) and the timeout counter.
// Ports:
//   clock, reset_n           clock and synchronous active-low reset
//   start, start_we/addr/wdata  launch a request from the next cycle on
//   mem_ack                  bus completion
//   mem_req/we/addr/wdata    registered request to the bus
//   done                     request ends at the coming edge (ack or timeout)
//   acked                    request ends because of an ack (ack beats timeout)
module mem_access_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic        start_we,
    input  logic [63:0] start_addr,
    input  logic [63:0] start_wdata,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic        done,
    output logic        acked
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic             req_r;
    logic             we_r;
    logic [63:0]      addr_r;
    logic [63:0]      wdata_r;
    logic [CNT_W-1:0] cnt_r;
    logic             acked_s;
    logic             timeout_s;

    // Completion decode; an ack seen in the last allowed cycle still counts as success.
    always_comb begin
        acked_s   = req_r && mem_ack;
        timeout_s = req_r && (cnt_r == CNT_LAST);
    end

    // Request registers and wait counter.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            req_r   <= 1'b0;
            we_r    <= 1'b0;
            addr_r  <= 64'd0;
            wdata_r <= 64'd0;
            cnt_r   <= '0;
        end else if (start) begin
            req_r   <= 1'b1;
            we_r    <= start_we;
            addr_r  <= start_addr;
            wdata_r <= start_wdata;
            cnt_r   <= '0;
        end else if (req_r) begin
            if (acked_s || timeout_s) begin
                req_r <= 1'b0;
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + 1'b1;
            end
        end
    end

    assign mem_req   = req_r;
    assign mem_we    = we_r;
    assign mem_addr  = addr_r;
    assign mem_wdata = wdata_r;
    assign done      = acked_s || timeout_s;
    assign acked     = acked_s;

endmodule

// File: rtl/memory_stage.sv
// Y86-64 memory stage between execute and write-back.
// Accepts one instruction over in_valid/in_ready, performs its data-memory
// access through mem_access_ctrl, and presents the result on out_valid/out_ready.
// After the first result whose status is not AOK has been handed over, the
// stage stops accepting work until reset.
// Ports:
//   clock, reset_n                clock and synchronous active-low reset
//   in_valid/in_ready, in_*       execute-side handshake and fields
//   mem_req/we/addr/wdata/ack/rdata  data-memory bus
//   out_valid/out_ready, out_*    write-back-side handshake and fields
module memory_stage
    import y86_pkg::*;
#(
    parameter logic [63:0] ADDR_MAX = 64'h0FFF,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_icode,
    input  logic [3:0]  in_ra,
    input  logic [3:0]  in_rb,
    input  logic        in_cnd,
    input  logic [63:0] in_val_e,
    input  logic [63:0] in_val_a,
    input  logic [63:0] in_val_p,
    input  logic [2:0]  in_stat,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_icode,
    output logic [3:0]  out_ra,
    output logic [3:0]  out_rb,
    output logic        out_cnd,
    output logic [63:0] out_val_e,
    output logic [63:0] out_val_m,
    output logic [2:0]  out_stat
);

    // Highest address at which a full 8-byte word still fits.
    localparam logic [63:0] ADDR_LAST_WORD = ADDR_MAX - 64'd7;

    stage_state_t state_r;
    logic         in_ready_r;
    logic         out_valid_r;
    logic [3:0]   out_icode_r;
    logic [3:0]   out_ra_r;
    logic [3:0]   out_rb_r;
    logic         out_cnd_r;
    logic [63:0]  out_val_e_r;
    logic [63:0]  out_val_m_r;
    logic [2:0]   out_stat_r;
    logic         read_r;

    mem_op_t      op_s;
    logic [63:0]  addr_s;
    logic [63:0]  wdata_s;
    logic         addr_bad_s;
    logic         accept_s;
    logic         start_s;
    logic         done_s;
    logic         acked_s;

    // Decode the offered instruction and check its address.
    always_comb begin
        op_s = decode_mem_op(in_icode);
        if (op_s.use_val_a_addr) begin
            addr_s = in_val_a;
        end else begin
            addr_s = in_val_e;
        end
        if (op_s.use_val_p_data) begin
            wdata_s = in_val_p;
        end else begin
            wdata_s = in_val_a;
        end
        // Unsigned compare also rejects addresses that wrap past 2^64.
        addr_bad_s = (addr_s > ADDR_LAST_WORD);
        accept_s   = in_valid && in_ready_r;
        start_s    = accept_s && (in_stat == STAT_AOK) && op_s.is_access && !addr_bad_s;
    end

    mem_access_ctrl #(
        .TIMEOUT (TIMEOUT)
    ) u_access (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start_s),
        .start_we    (op_s.is_write),
        .start_addr  (addr_s),
        .start_wdata (wdata_s),
        .mem_ack     (mem_ack),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .done        (done_s),
        .acked       (acked_s)
    );

    // Stage FSM with registered handshake and result fields.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_icode_r <= 4'd0;
            out_ra_r    <= 4'd0;
            out_rb_r    <= 4'd0;
            out_cnd_r   <= 1'b0;
            out_val_e_r <= 64'd0;
            out_val_m_r <= 64'd0;
            out_stat_r  <= 3'd0;
            read_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        in_ready_r  <= 1'b0;
                        out_icode_r <= in_icode;
                        out_ra_r    <= in_ra;
                        out_rb_r    <= in_rb;
                        out_cnd_r   <= in_cnd;
                        out_val_e_r <= in_val_e;
                        out_val_m_r <= 64'd0;
                        read_r      <= !op_s.is_write;
                        if (in_stat != STAT_AOK) begin
                            state_r     <= ST_HOLD;
                            out_valid_r <= 1'b1;
                            out_stat_r  <= in_stat;
                        end else if (!op_s.is_access) begin
                            state_r     <= ST_HOLD;
                            out_valid_r <= 1'b1;
                            out_stat_r  <= STAT_AOK;
                        end else if (addr_bad_s) begin
                            state_r     <= ST_HOLD;
                            out_valid_r <= 1'b1;
                            out_stat_r  <= STAT_ADR;
                        end else begin
                            state_r <= ST_ACCESS;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (done_s) begin
                        state_r     <= ST_HOLD;
                        out_valid_r <= 1'b1;
                        if (acked_s) begin
                            out_stat_r  <= STAT_AOK;
                            out_val_m_r <= read_r ? mem_rdata : 64'd0;
                        end else begin
                            out_stat_r  <= STAT_ADR;
                            out_val_m_r <= 64'd0;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        if (out_stat_r == STAT_AOK) begin
                            state_r    <= ST_IDLE;
                            in_ready_r <= 1'b1;
                        end else begin
                            state_r <= ST_HALTED;
                        end
                    end
                end
                ST_HALTED: begin
                    in_ready_r  <= 1'b0;
                    out_valid_r <= 1'b0;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_icode = out_icode_r;
    assign out_ra    = out_ra_r;
    assign out_rb    = out_rb_r;
    assign out_cnd   = out_cnd_r;
    assign out_val_e = out_val_e_r;
    assign out_val_m = out_val_m_r;
    assign out_stat  = out_stat_r;

endmodule
